// File: rtl/table_port_sched_pkg.sv
// Shared types and constants for the table port-A scheduler and its clients.
package table_port_sched_pkg;

  localparam int MEMORYA_WORDS = 16;

  typedef struct packed {
    logic        vld;
    logic [14:0] val;
  } aMemSt;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } tpsStateE;

endpackage

// File: rtl/table_port_sched_if.sv
// Client-side request/response bundle for the two port-A requesters.
interface table_port_sched_if
  import table_port_sched_pkg::*;
#(
  parameter int  AW     = $clog2(MEMORYA_WORDS),
  parameter type data_t = aMemSt
);

  logic          c0_req;
  logic          c0_write;
  logic [AW-1:0] c0_addr;
  data_t         c0_wdata;
  logic          c0_gnt;
  logic          c0_rvalid;
  data_t         c0_rdata;

  logic          c1_req;
  logic          c1_write;
  logic [AW-1:0] c1_addr;
  data_t         c1_wdata;
  logic          c1_gnt;
  logic          c1_rvalid;
  data_t         c1_rdata;

  modport master (
    output c0_req, c0_write, c0_addr, c0_wdata,
    input  c0_gnt, c0_rvalid, c0_rdata,
    output c1_req, c1_write, c1_addr, c1_wdata,
    input  c1_gnt, c1_rvalid, c1_rdata
  );

  modport slave (
    input  c0_req, c0_write, c0_addr, c0_wdata,
    output c0_gnt, c0_rvalid, c0_rdata,
    input  c1_req, c1_write, c1_addr, c1_wdata,
    output c1_gnt, c1_rvalid, c1_rdata
  );

endinterface

// File: rtl/table_port_sched_rr_arb2.sv
// Two-way round-robin arbiter; combinational grant, pointer tracks the last winner.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 1 = client 1 was granted most recently, so client 0 wins the first tie.
  logic last;

  always_comb begin
    gnt = '0;
    if (en) begin
      if (req[0] && (!req[1] || last)) begin
        gnt[0] = 1'b1;
      end else if (req[1]) begin
        gnt[1] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (|gnt) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/table_port_sched.sv
// Port-A scheduler: round-robin between lookup and update clients, plus table clear.
module table_port_sched
  import table_port_sched_pkg::*;
#(
  parameter int  DEPTH          = MEMORYA_WORDS,
  parameter type data_t         = aMemSt,
  parameter int  AW             = $clog2(DEPTH),
  parameter bit  CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  table_port_sched_if.slave cl,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              mem_en,
  output logic              mem_write,
  output logic [AW-1:0]     mem_addr,
  output data_t             mem_wdata,
  input  data_t             mem_rdata
);

  localparam logic [AW:0] CLR_LAST = (AW+1)'(DEPTH - 1);

  tpsStateE    state;
  logic [AW:0] clr_cnt;
  logic [AW:0] clr_addr;
  logic        clr_wr;
  logic        arb_en;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        rd_pend;
  logic        rd_id;

  // A clr_start seen in RUN issues the address-0 write in the same cycle,
  // so the CLEAR state itself begins at address 1 in that case.
  assign clr_wr   = !rst && ((state == CLEAR) || clr_start);
  assign clr_addr = (state == CLEAR) ? clr_cnt : '0;
  assign arb_en   = !rst && !clr_wr;
  assign req      = {cl.c1_req, cl.c0_req};

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req (req),
    .gnt (gnt)
  );

  assign cl.c0_gnt    = gnt[0];
  assign cl.c1_gnt    = gnt[1];
  assign cl.c0_rvalid = rd_pend && !rd_id;
  assign cl.c1_rvalid = rd_pend &&  rd_id;
  assign cl.c0_rdata  = mem_rdata;
  assign cl.c1_rdata  = mem_rdata;

  always_comb begin
    mem_en    = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (clr_wr) begin
      mem_en    = 1'b1;
      mem_write = 1'b1;
      mem_addr  = clr_addr[AW-1:0];
    end else if (gnt[0]) begin
      mem_en    = 1'b1;
      mem_write = cl.c0_write;
      mem_addr  = cl.c0_addr;
      mem_wdata = cl.c0_wdata;
    end else if (gnt[1]) begin
      mem_en    = 1'b1;
      mem_write = cl.c1_write;
      mem_addr  = cl.c1_addr;
      mem_wdata = cl.c1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_cnt  <= '0;
      clr_busy <= CLEAR_ON_RESET;
      clr_done <= 1'b0;
      rd_pend  <= 1'b0;
      rd_id    <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      rd_pend  <= (gnt[0] && !cl.c0_write) || (gnt[1] && !cl.c1_write);
      rd_id    <= gnt[1];
      if (clr_wr) begin
        clr_busy <= 1'b1;
        if (clr_addr == CLR_LAST) begin
          state    <= RUN;
          clr_cnt  <= '0;
          clr_done <= 1'b1;
        end else begin
          state    <= CLEAR;
          clr_cnt  <= clr_addr + 1'b1;
        end
      end else if (clr_done) begin
        clr_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_table_port_sched.sv
// Directed scoreboard bench for table_port_sched with a 16-entry port-A memory model.
module tb_table_port_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_start;
  logic        clr_busy;
  logic        clr_done;
  logic        mem_en;
  logic        mem_write;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] mem [16];
  logic [15:0] c0_rd;
  logic [15:0] c1_rd;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  int t_clr;
  bit found;

  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  int          glog_c [$];
  int          glog_t [$];

  always #5 clk = ~clk;

  table_port_sched_if #(.AW(4)) cif ();

  table_port_sched #(
    .DEPTH          (16),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cl        (cif),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .mem_en    (mem_en),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  assign c0_rd = cif.c0_rdata;
  assign c1_rd = cif.c1_rdata;

  // Port-A memory: 1-cycle read latency, preloaded with non-zero contents.
  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (cyc_n == 0) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'hA000 + 16'(i);
    end else if (mem_en) begin
      if (mem_write) mem[mem_addr] <= mem_wdata;
      else           mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Response monitor and grant logger.
  always @(negedge clk) begin
    if (!rst) begin
      if (cif.c0_rvalid) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL c0_rvalid_unexpected actual=1 expected=0");
        end else check("c0_rdata", 32'(c0_rd), 32'(q0.pop_front()));
      end
      if (cif.c1_rvalid) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL c1_rvalid_unexpected actual=1 expected=0");
        end else check("c1_rdata", 32'(c1_rd), 32'(q1.pop_front()));
      end
      if (cif.c0_gnt && cif.c1_gnt) begin
        checks++; errors++;
        $display("FAIL dual_gnt actual=11 expected=one-hot");
      end
      if (cif.c0_gnt) begin glog_c.push_back(0); glog_t.push_back(cyc_n); end
      if (cif.c1_gnt) begin glog_c.push_back(1); glog_t.push_back(cyc_n); end
    end
  end

  task automatic access(input int c, input logic wr, input logic [3:0] a,
                        input logic [15:0] d, input string tag);
    logic got;
    if (c == 0) begin
      cif.c0_req = 1'b1; cif.c0_write = wr; cif.c0_addr = a; cif.c0_wdata = d;
    end else begin
      cif.c1_req = 1'b1; cif.c1_write = wr; cif.c1_addr = a; cif.c1_wdata = d;
    end
    got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      got = (c == 0) ? cif.c0_gnt : cif.c1_gnt;
    end
    check({tag, "_granted"}, 32'(got), 32'd1);
    if (got && !wr) begin
      if (c == 0) q0.push_back(d);
      else        q1.push_back(d);
    end
    @(posedge clk); #1;
    if (c == 0) cif.c0_req = 1'b0;
    else        cif.c1_req = 1'b0;
  endtask

  task automatic check_glog(input string tag, input int n, input int first_c, input bit alt);
    int m;
    check({tag, "_count"}, 32'(glog_c.size()), 32'(n));
    m = (glog_c.size() < n) ? glog_c.size() : n;
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s_client%0d", tag, i), 32'(glog_c[i]),
            32'(alt ? (first_c ^ (i & 1)) : first_c));
      if (i > 0) check($sformatf("%s_cycle%0d", tag, i), 32'(glog_t[i] - glog_t[0]), 32'(i));
    end
    glog_c.delete();
    glog_t.delete();
  endtask

  initial begin
    rst = 1'b1; clr_start = 1'b0;
    cif.c0_req = 1'b0; cif.c0_write = 1'b0; cif.c0_addr = '0; cif.c0_wdata = '0;
    cif.c1_req = 1'b0; cif.c1_write = 1'b0; cif.c1_addr = '0; cif.c1_wdata = '0;
    repeat (2) @(posedge clk); #1;

    // Reset state, then the automatic clear with c0 waiting to read address 5.
    fork
      access(0, 1'b0, 4'd5, 16'h0000, "autoclr_rd");
      begin
        @(negedge clk);
        check("rst_gnt0", 32'(cif.c0_gnt), 0);
        check("rst_gnt1", 32'(cif.c1_gnt), 0);
        check("rst_rvalid0", 32'(cif.c0_rvalid), 0);
        check("rst_rvalid1", 32'(cif.c1_rvalid), 0);
        check("rst_done", 32'(clr_done), 0);
        check("rst_mem_write", 32'(mem_write), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_busy", 32'(clr_busy), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
          @(negedge clk);
          check($sformatf("aclr_write%0d", i), 32'({mem_en, mem_write}), 32'h3);
          check($sformatf("aclr_addr%0d", i), 32'(mem_addr), 32'(i));
          check($sformatf("aclr_wdata%0d", i), 32'(mem_wdata), 0);
          check($sformatf("aclr_busy%0d", i), 32'(clr_busy), 1);
          check($sformatf("aclr_done%0d", i), 32'(clr_done), 0);
          check($sformatf("aclr_gnt0_%0d", i), 32'(cif.c0_gnt), 0);
        end
        @(negedge clk);
        check("aclr_done_pulse", 32'(clr_done), 1);
        check("aclr_done_busy", 32'(clr_busy), 1);
        check("aclr_first_gnt", 32'(cif.c0_gnt), 1);
        @(negedge clk);
        check("aclr_done_after", 32'(clr_done), 0);
        check("aclr_busy_after", 32'(clr_busy), 0);
      end
    join
    @(posedge clk); #1;
    glog_c.delete(); glog_t.delete();

    // Write then read the same address on consecutive grants.
    access(0, 1'b1, 4'd3, 16'h0005, "wr3");
    access(0, 1'b0, 4'd3, 16'h0005, "rd3");
    check_glog("wr_rd", 2, 0, 1'b0);

    access(0, 1'b1, 4'd1, 16'h0111, "wr1");
    access(1, 1'b1, 4'd2, 16'h0222, "wr2");
    glog_c.delete(); glog_t.delete();

    // Client 1 alone: eight back-to-back reads.
    repeat (8) access(1, 1'b0, 4'd2, 16'h0222, "c1_rd");
    check_glog("c1_only", 8, 1, 1'b0);

    // Both clients continuously: alternation starting with client 0.
    fork
      repeat (4) access(0, 1'b0, 4'd1, 16'h0111, "tie_c0");
      repeat (4) access(1, 1'b0, 4'd2, 16'h0222, "tie_c1");
    join
    check_glog("tie", 8, 0, 1'b1);

    // clr_start coincident with a c0 read; a second clr_start mid-clear is ignored.
    t_clr = cyc_n;
    fork
      access(0, 1'b0, 4'd3, 16'h0000, "clr_stall_rd");
      begin
        clr_start = 1'b1;
        @(negedge clk);
        check("clr_t0_gnt0", 32'(cif.c0_gnt), 0);
        check("clr_t0_write", 32'({mem_en, mem_write}), 32'h3);
        check("clr_t0_addr", 32'(mem_addr), 0);
        check("clr_t0_wdata", 32'(mem_wdata), 0);
        check("clr_t0_busy", 32'(clr_busy), 0);
        @(posedge clk); #1;
        clr_start = 1'b0;
        for (int k = 1; k < 16; k++) begin
          @(negedge clk);
          check($sformatf("clr_busy%0d", k), 32'(clr_busy), 1);
          check($sformatf("clr_addr%0d", k), 32'(mem_addr), 32'(k));
          check($sformatf("clr_write%0d", k), 32'(mem_write), 1);
          check($sformatf("clr_gnt0_%0d", k), 32'(cif.c0_gnt), 0);
          check($sformatf("clr_done%0d", k), 32'(clr_done), 0);
        end
        @(negedge clk);
        check("clr_done_pulse", 32'(clr_done), 1);
        check("clr_done_busy", 32'(clr_busy), 1);
        check("clr_done_gnt0", 32'(cif.c0_gnt), 1);
      end
      begin
        repeat (5) @(posedge clk);
        #1 clr_start = 1'b1;
        @(posedge clk);
        #1 clr_start = 1'b0;
      end
    join
    check("clr_stall_count", 32'(glog_c.size()), 1);
    if (glog_t.size() > 0) check("clr_stall_cycle", 32'(glog_t[0] - t_clr), 32'd16);
    glog_c.delete(); glog_t.delete();

    // Reset while the clear is at address 7: restart from 0, one done pulse.
    @(posedge clk); #1;
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (mem_addr == 4'd7) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("mid_addr7_seen", 32'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_write", 32'(mem_write), 0);
    check("mid_rst_addr", 32'(mem_addr), 0);
    check("mid_rst_done", 32'(clr_done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("mid_addr%0d", i), 32'(mem_addr), 32'(i));
      check($sformatf("mid_write%0d", i), 32'(mem_write), 1);
      check($sformatf("mid_done%0d", i), 32'(clr_done), 0);
      check($sformatf("mid_busy%0d", i), 32'(clr_busy), 1);
    end
    @(negedge clk);
    check("mid_done_pulse", 32'(clr_done), 1);
    repeat (2) begin
      @(negedge clk);
      check("mid_done_single", 32'(clr_done), 0);
    end

    repeat (3) @(posedge clk);
    check("q0_drained", 32'(q0.size()), 0);
    check("q1_drained", 32'(q1.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
